// File: rtl/ipd_sat_ctrl.sv
// I-PD servo controller: integral on error, P and D on measurement, one shared multiplier, saturating fixed point.
// Latency: en to valid is 8 cycles. An en that arrives while busy is dropped, with no queueing and no backpressure.
module ipd_sat_ctrl #(
    parameter int cant_bits = 16,
    parameter int frac_bits = 7,
    parameter bit round_en  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [cant_bits-1:0] Pot,
    input  logic signed [cant_bits-1:0] Ref,
    input  logic signed [cant_bits-1:0] Kp,
    input  logic signed [cant_bits-1:0] Ki,
    input  logic signed [cant_bits-1:0] Kd,
    output logic signed [cant_bits-1:0] salida,
    output logic                        valid,
    output logic                        busy,
    output logic [1:0]                  sat
);

    localparam int W  = cant_bits;
    localparam int PW = 2 * cant_bits;
    localparam int SW = 2 * cant_bits + 1;

    localparam logic signed [W-1:0]  MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] MAX_X = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_X = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] RND_X = round_en ? (SW'(1) << (frac_bits - 1)) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ERR,
        S_MUL_I,
        S_MUL_P,
        S_MUL_D,
        S_SUM,
        S_OUT
    } state_t;

    // Every narrower intermediate is sign-extended to SW bits before it is clamped here.
    function automatic logic signed [W-1:0] sat_x(input logic signed [SW-1:0] x);
        if (x > MAX_X) begin
            return MAX_W;
        end else if (x < MIN_X) begin
            return MIN_W;
        end
        return x[W-1:0];
    endfunction

    state_t                state_q;
    logic signed [W-1:0]   y_q, r_q, kp_q, ki_q, kd_q;
    logic signed [W-1:0]   e_q, dy_q, pi_q, pp_q, pd_q;
    logic signed [W-1:0]   i_q, yprev_q, salida_q;
    logic signed [W+1:0]   u_q;
    logic [1:0]            sat_q;
    logic                  valid_q, busy_q;

    logic signed [W:0]     e_wide, dy_wide;
    logic signed [W-1:0]   e_d, dy_d;
    logic signed [W-1:0]   op_a, op_b;
    logic signed [PW-1:0]  prod;
    logic signed [SW-1:0]  prod_x, prod_sh;
    logic signed [W-1:0]   scaled_d;
    logic signed [SW-1:0]  i_sum;
    logic signed [W-1:0]   i_d;
    logic signed [W+1:0]   u_d;
    logic signed [W-1:0]   out_d;
    logic [1:0]            sat_d;

    assign e_wide  = (W+1)'(r_q) - (W+1)'(y_q);
    assign dy_wide = (W+1)'(y_q) - (W+1)'(yprev_q);
    assign e_d     = sat_x(SW'(e_wide));
    assign dy_d    = sat_x(SW'(dy_wide));

    // The single multiplier is shared by the three MUL states through this operand mux.
    always_comb begin
        op_a = kd_q;
        op_b = dy_q;
        case (state_q)
            S_MUL_I: begin
                op_a = ki_q;
                op_b = e_q;
            end
            S_MUL_P: begin
                op_a = kp_q;
                op_b = y_q;
            end
            default: ;
        endcase
    end

    assign prod     = PW'(op_a) * PW'(op_b);
    assign prod_x   = SW'(prod) + RND_X;
    assign prod_sh  = prod_x >>> frac_bits;
    assign scaled_d = sat_x(prod_sh);

    // Anti-windup: do not integrate further into a rail that the last output already hit.
    assign i_sum = SW'(i_q) + SW'(pi_q);
    always_comb begin
        i_d = sat_x(i_sum);
        if (sat_q[1] && !pi_q[W-1] && (pi_q != '0)) begin
            i_d = i_q;
        end else if (sat_q[0] && pi_q[W-1]) begin
            i_d = i_q;
        end
    end

    assign u_d   = (W+2)'(i_d) - (W+2)'(pp_q) - (W+2)'(pd_q);
    assign out_d = sat_x(SW'(u_q));
    assign sat_d = {SW'(u_q) > MAX_X, SW'(u_q) < MIN_X};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            y_q      <= '0;
            r_q      <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            e_q      <= '0;
            dy_q     <= '0;
            pi_q     <= '0;
            pp_q     <= '0;
            pd_q     <= '0;
            i_q      <= '0;
            yprev_q  <= '0;
            u_q      <= '0;
            salida_q <= '0;
            sat_q    <= 2'b00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    y_q     <= Pot;
                    r_q     <= Ref;
                    kp_q    <= Kp;
                    ki_q    <= Ki;
                    kd_q    <= Kd;
                    state_q <= S_ERR;
                end
                S_ERR: begin
                    e_q     <= e_d;
                    dy_q    <= dy_d;
                    state_q <= S_MUL_I;
                end
                S_MUL_I: begin
                    pi_q    <= scaled_d;
                    state_q <= S_MUL_P;
                end
                S_MUL_P: begin
                    pp_q    <= scaled_d;
                    state_q <= S_MUL_D;
                end
                S_MUL_D: begin
                    pd_q    <= scaled_d;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    i_q     <= i_d;
                    u_q     <= u_d;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    salida_q <= out_d;
                    sat_q    <= sat_d;
                    yprev_q  <= y_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign salida = salida_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign sat    = sat_q;

endmodule

// File: doc/ipd_sat_ctrl.md
Name: ipd_sat_ctrl

Overview:
- Parametrised I-PD servo controller and successor to the fixed 16-bit truncating IPD block.
- Integral action acts on the error (Ref − Pot); proportional and derivative act on the measurement (Pot) only.
- Gains are runtime ports. A single shared multiplier runs through a fixed-latency FSM.
- Every intermediate is rounded or truncated (selectable) and then saturated. The integrator has anti-windup.
- Sits between the ADC sample path (Pot) and the PWM duty generator (salida).

Parameters:
- cant_bits, 16, width of all signed data and gain ports.
- frac_bits, 7, fractional bits of the fixed-point format (default Q9.7, so 16'h4B00 = 150.0).
- round_en, 1, product scaling mode: 1 = round half up (add 2^(frac_bits−1) before the arithmetic shift); 0 = truncate (plain arithmetic shift).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; one-cycle pulse starts a control update.
- Pot  in  cant_bits  signed measured position.
- Ref  in  cant_bits  signed setpoint.
- Kp  in  cant_bits  signed proportional gain, same Q format.
- Ki  in  cant_bits  signed integral gain (per sample).
- Kd  in  cant_bits  signed derivative gain (per sample).
- salida  out  cant_bits  signed saturated control output.
- valid  out  1  one-cycle pulse when salida updates.
- busy  out  1  high while an update is in progress.
- sat  out  2  {sat_hi, sat_lo} flags from the last output saturation.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - salida=0, valid=0, busy=0, sat=2'b00.
  - Integrator I=0, y_prev=0, FSM to IDLE.
  - Reset mid-update aborts the update; no valid pulse is issued.
- Definitions:
  - SAT(x): clamp to [−2^(cant_bits−1), 2^(cant_bits−1)−1].
  - SCALE(a*b): full 2·cant_bits product, then round or truncate per round_en, shift right by frac_bits, then SAT.
- FSM: IDLE→LATCH→ERR→MUL_I→MUL_P→MUL_D→SUM→OUT→IDLE. Each state lasts one cycle.
  - IDLE: en=1 moves to LATCH and sets busy=1. en=0 stays in IDLE.
  - LATCH: register Pot→y, Ref→r, Kp, Ki and Kd. Inputs may change freely afterwards.
  - ERR: e=SAT(r−y), dy=SAT(y−y_prev), both computed at cant_bits+1 width.
  - MUL_I: pI=SCALE(Ki*e). Uses the shared multiplier.
  - MUL_P: pP=SCALE(Kp*y). Uses the shared multiplier.
  - MUL_D: pD=SCALE(Kd*dy). Uses the shared multiplier.
  - SUM, integrator update with anti-windup:
    - If sat_hi=1 and pI>0, hold I.
    - Else if sat_lo=1 and pI<0, hold I.
    - Else I=SAT(I+pI).
    - Compute u=I−pP−pD at cant_bits+2 width.
  - OUT: salida=SAT(u); sat_hi=(u>max); sat_lo=(u<min); y_prev=y; valid=1 for this cycle; busy=0.
- Latency: en sampled high at edge k gives valid high in the cycle after edge k+7, with salida updated at that same edge. Back-to-back updates are possible every 8 cycles.
- en while busy=1 is ignored; there is no queueing.
- salida holds its value between updates.
- First update after reset uses y_prev=0.
- Gain changes take effect only at LATCH.
- Both saturation directions are symmetric. The most-negative value is reachable; no negation of inputs is performed, only subtraction through widened adders.

Test Plan:
1. Reset then integral: Ref=16'h4B00, Pot=0, Kp=0, Ki=16'h0040 (0.5), Kd=0, two en pulses 16 cycles apart.
   - Required: salida=16'h2580 then 16'h4B00, with valid exactly 8 cycles after each en.
   - Required: busy high for 7 cycles.
2. Proportional on measurement: Ref=0, Pot=16'h0500 (10.0), Kp=16'h0100 (2.0), Ki=Kd=0.
   - Required: salida=16'hF600 (−20.0), sat=00.
3. Derivative: Kd=16'h0080, Kp=Ki=0; Pot sequence 0, 16'h0500, 16'h0500.
   - Required: salida sequence 0, 16'hFB00, 0.
4. Saturation and anti-windup: Ref=16'h7FFF, Pot=16'h8000, Ki=16'h0080.
   - Required: e saturates, salida=16'h7FFF, sat=10; a second identical pulse leaves I unchanged.
   - Then Ref=0, Pot=16'h0500, Kp=0: required salida=16'h7AFF, sat=00.
5. Rounding mode: Kp=16'h0001, Pot=16'h0040, Ref=Ki=Kd=0.
   - Required: round_en=1 gives salida=16'hFFFF; round_en=0 gives salida=16'h0000.
6. Protocol:
   - en re-pulsed on cycles 2 and 5 of a busy update is ignored: exactly one valid.
   - rst asserted during MUL_P: no valid, salida=0, and the next update behaves as the first after reset.
